// File: rtl/mac_acc_pkg.sv
// Shared encodings for the MAC accumulator stage: lane-fusion modes, FSM states,
// and the mapping from mode to carry-chained group size.
package mac_acc_pkg;

  typedef enum logic [1:0] {
    MAC_SINGLE = 2'b00,
    MAC_DUAL   = 2'b01,
    MAC_QUAD   = 2'b10
  } mac_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } mac_state_e;

  // Reserved mode 11 falls back to independent lanes.
  function automatic logic [2:0] group_size(input logic [1:0] mode);
    case (mode)
      MAC_DUAL: group_size = 3'd2;
      MAC_QUAD: group_size = 3'd4;
      default:  group_size = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mac_acc_block_n_if.sv
// Config, input-beat and result channels of the accumulator stage; master drives
// config/input and out_ready, slave is the accumulator.
interface mac_acc_block_n_if #(
  parameter int NUM_LANES     = 4,
  parameter int MAC_ACC_WIDTH = 32,
  parameter int CNT_WIDTH     = 16
);
  localparam int DW = NUM_LANES * MAC_ACC_WIDTH;

  logic                 cfg_valid;
  logic [1:0]           cfg_mode;
  logic                 cfg_acc_en;
  logic [CNT_WIDTH-1:0] cfg_len;
  logic [DW-1:0]        cfg_init;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [NUM_LANES-1:0] out_ovf;

  modport master (
    output cfg_valid, cfg_mode, cfg_acc_en, cfg_len, cfg_init,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_acc_en, cfg_len, cfg_init,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/mac_acc_lane.sv
// One accumulator lane: register plus adder with chained carry; load wins over add,
// and the clamp forces all-ones on an add cycle. Carry-out is combinational.
module mac_acc_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         add_en,
  input  logic [W-1:0] addend,
  input  logic         cin,
  input  logic         sat,
  output logic [W-1:0] acc,
  output logic         cout
);

  logic [W:0] sum;

  assign sum  = {1'b0, acc} + {1'b0, addend} + {{W{1'b0}}, cin};
  assign cout = sum[W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (add_en) begin
      acc <= sat ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/mac_acc_block_n.sv
// Multi-lane beat accumulator with 1/2/4-lane carry fusion, or a 1-deep pass-through;
// result one cycle after the last beat, held until out_ready. MAC_ACC_SAT_EN selects saturation.
module mac_acc_block_n
  import mac_acc_pkg::*;
#(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int MAC_ACC_WIDTH = 32,
  parameter int NUM_LANES     = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic              clk,
  input  logic              rst,
  mac_acc_block_n_if.slave  bus
);

  localparam int W = MAC_ACC_WIDTH;

  if ((NUM_LANES % 4 != 0) || (MAC_MIN_WIDTH > MAC_ACC_WIDTH)) begin : g_param_check
    $error("mac_acc_block_n: NUM_LANES must be a multiple of 4 and MAC_MIN_WIDTH <= MAC_ACC_WIDTH");
  end

  mac_state_e           state, state_d;
  logic [1:0]           mode;
  logic                 acc_en;
  logic [CNT_WIDTH-1:0] len, cnt, eff_len;
  logic [NUM_LANES-1:0] ovf, grp_ovf;
  logic                 out_valid, rdy, beat, out_hs;
  logic                 cfg_take, lane_load, lane_add;
  logic [2:0]           gsz;

  assign eff_len = (len == '0) ? CNT_WIDTH'(1) : len;
  assign gsz     = group_size(mode);
  assign beat    = bus.in_valid && rdy;
  assign out_hs  = out_valid && bus.out_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic         c_in, c_out, top_c, sat;
    logic [W-1:0] acc_q, load_val;

    if (i == 0) begin : g_c0
      assign c_in = 1'b0;
    end else begin : g_cn
      assign c_in = (i % gsz != 0) ? g_lane[i-1].c_out : 1'b0;
    end

    // Carry out of the group's top lane is the group overflow; it is dropped from the sum.
    assign top_c = (gsz == 3'd4) ? g_lane[i | 3].c_out :
                   (gsz == 3'd2) ? g_lane[i | 1].c_out : c_out;
    assign grp_ovf[i] = top_c;

`ifdef MAC_ACC_SAT_EN
    assign sat = ovf[i] || top_c;
`else
    assign sat = 1'b0;
`endif

    assign load_val = (state == IDLE) ? bus.cfg_init[i*W +: W] : bus.in_data[i*W +: W];

    mac_acc_lane #(.W(W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (lane_load),
      .load_val (load_val),
      .add_en   (lane_add),
      .addend   (bus.in_data[i*W +: W]),
      .cin      (c_in),
      .sat      (sat),
      .acc      (acc_q),
      .cout     (c_out)
    );

    assign bus.out_data[i*W +: W] = acc_q;
  end

  always_comb begin
    state_d   = state;
    rdy       = 1'b0;
    cfg_take  = 1'b0;
    lane_load = 1'b0;
    lane_add  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cfg_valid) begin
          cfg_take  = 1'b1;
          lane_load = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (acc_en) begin
          rdy = 1'b1;
          if (bus.in_valid) begin
            lane_add = 1'b1;
            if (cnt + CNT_WIDTH'(1) == eff_len) state_d = HOLD;
          end
        end else begin
          // Pass-through reuses the lane registers as the single output stage.
          rdy       = (cnt != eff_len) && (!out_valid || bus.out_ready);
          lane_load = bus.in_valid && rdy;
          if (out_hs && cnt == eff_len) state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= '0;
      acc_en    <= 1'b0;
      len       <= '0;
      cnt       <= '0;
      ovf       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (cfg_take) begin
        mode   <= bus.cfg_mode;
        acc_en <= bus.cfg_acc_en;
        len    <= bus.cfg_len;
        cnt    <= '0;
        ovf    <= '0;
      end else if (beat) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
      if (lane_add) ovf <= ovf | grp_ovf;
      if ((lane_add && state_d == HOLD) || (beat && !acc_en)) out_valid <= 1'b1;
      else if (out_hs)                                        out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid;
  assign bus.out_ovf   = ovf;

endmodule

// File: doc/mac_acc_block_n.md
Name: mac_acc_block_n

Overview:
Parametrised successor accumulator stage for the MAC datapath. It takes NUM_LANES lanes of MAC_ACC_WIDTH partial products and accumulates them over a programmed number of beats. Adjacent lanes can be fused into 2-lane or 4-lane carry-chained accumulators. The block uses valid/ready handshakes on both sides and sits between the multiplier array and the writeback/output buffer.

Parameters:
MAC_MIN_WIDTH, 8, minimum operand width (kept for consistency with the rest of the MAC hierarchy)
MAC_ACC_WIDTH, 32, width of one accumulator lane
NUM_LANES, 4, lane count; must be a multiple of 4
CNT_WIDTH, 16, width of the beat counter and of cfg_len

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cfg_valid  in  1  load configuration; honoured only in IDLE
cfg_mode  in  2  00 single, 01 dual (lane pairs fused), 10 quad (lane quads fused), 11 reserved (treated as single)
cfg_acc_en  in  1  1 = accumulate; 0 = multiply-only pass-through
cfg_len  in  CNT_WIDTH  beats per session; 0 is treated as 1
cfg_init  in  NUM_LANES*MAC_ACC_WIDTH  initial accumulator values, lane 0 in the LSBs
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  NUM_LANES*MAC_ACC_WIDTH  per-lane addends
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  NUM_LANES*MAC_ACC_WIDTH  per-lane results
out_ovf  out  NUM_LANES  sticky per-lane overflow flag; valid with out_valid

Behaviour:
- Reset (asynchronous) sets: state IDLE; all accumulators, counter, mode regs, out_data and out_ovf to 0; in_ready=0; out_valid=0. A reset mid-session discards all accumulated data.
- States and transitions:
  - IDLE: in_ready=0. On cfg_valid, latch mode, acc_en and len, load accumulators from cfg_init, clear the counter and ovf, then go to RUN. cfg_valid is ignored in all other states.
  - RUN, acc_en=1: in_ready=1. On each in_valid&&in_ready, acc[i] <= acc[i] + in[i] + cin[i] and the counter increments. After the beat that brings the count to cfg_len, go to HOLD the following cycle with out_valid=1 and out_data = accumulators.
  - RUN, acc_en=0: 1-entry pipeline. in_ready = !out_valid || out_ready. Each accepted beat appears on out_data with out_valid=1 one cycle later. The counter counts accepted beats; after beat cfg_len has been emitted and handshaken, go to IDLE.
  - HOLD: out_valid=1, out_data and out_ovf held stable, in_ready=0. On out_ready, go to IDLE the next cycle with out_valid=0.
- Carry rules:
  - Group size G is 1, 2 or 4 per mode.
  - cin[i] = cout[i-1] when i mod G != 0; otherwise cin[i] = 0.
  - The carry out of the top lane of each group is dropped, so the group wraps modulo 2^(G*MAC_ACC_WIDTH).
- out_ovf: set on every lane of a group when that group's top-lane carry-out is 1 on any beat; sticky until the next cfg load. Always 0 when acc_en=0.
- Simultaneous cfg_valid and in_valid in IDLE: only the config is taken; in_ready=0 that cycle.
- Latency: last accumulate beat to out_valid is 1 cycle; pass-through latency is 1 cycle.

Optional Feature:
MAC_ACC_SAT_EN
- Defined: on a group overflow, every lane of the group is clamped to all-ones and held there for the rest of the session. out_ovf behaves as in the default build.
- Undefined: wrap-around arithmetic as described in Behaviour, with out_ovf reporting the wrap.

Decomposition:
- Shared package mac_acc_pkg holds:
  - mode encodings MAC_SINGLE=00, MAC_DUAL=01, MAC_QUAD=10
  - state encoding IDLE/RUN/HOLD
  - group-size function of mode
- Sub-module mac_acc_lane: one lane register with adder, carry_in/carry_out, load, and the saturate clamp input. The top level instantiates NUM_LANES of these.

Test Plan:
1. Single, init 0, len 3, lane0 in = 0xFFFFFFFF, 1, 2, other lanes 0 -> out lane0=0x00000002, lane1=0, out_ovf[0]=1.
2. Dual, lane0 init 0xFFFFFFFF, len 1, lane0 in 1 -> lane0=0, lane1=1, lane2=0, out_ovf=0.
3. Quad, lanes0-2 init 0xFFFFFFFF, lane3 init 0, lane0 in 1 -> lanes0-2=0, lane3=1. With MAC_ACC_SAT_EN, init all four lanes 0xFFFFFFFF, add 1 -> all lanes 0xFFFFFFFF, out_ovf=4'hF.
4. Backpressure: in HOLD, out_ready=0 for 5 cycles -> out_valid=1, out_data stable, in_ready=0. Then out_ready=1 -> IDLE next cycle, out_valid=0.
5. Pass-through, len 2, in 0xA then 0xB back-to-back with out_ready=1 -> outputs 0xA, 0xB one cycle later each. With out_ready=0 and out_valid=1 -> in_ready=0; then back to IDLE after the 2nd handshake.
6. rst asserted after 2 of 4 beats in RUN -> asynchronous clear, out_valid=0, in_ready=0. A new cfg_valid starts a clean session with the result equal to init plus the new beats only.
